// File: rtl/pcie_7x_link_seq_if.sv
// Board-side bundle between the PCIe link sequencer and its environment.
// master is the sequencer; slave is the board wrapper / stimulus side.
interface pcie_7x_link_seq_if;
  logic       lnk_up;
  logic       force_retrain;
  logic       core_rst_n;
  logic       link_ok;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [2:0] led;

  modport master (
    input  lnk_up, force_retrain,
    output core_rst_n, link_ok, fail, state, retry_cnt, led
  );

  modport slave (
    output lnk_up, force_retrain,
    input  core_rst_n, link_ok, fail, state, retry_cnt, led
  );
endinterface

// File: rtl/pcie_7x_link_seq.sv
// PCIe core reset/link sequencer: hold reset, wait for debounced link-up, retry on loss/timeout.
// All outputs registered; link-up seen DEBOUNCE+3 edges after lnk_up rises; no backpressure.
module pcie_7x_link_seq #(
  parameter int unsigned RST_CYCLES   = 100000,
  parameter int unsigned LINK_TIMEOUT = 10000000,
  parameter int unsigned DEBOUNCE     = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned HB_BITS      = 26
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  pcie_7x_link_seq_if.master bus
);
  localparam int unsigned TMAX = (RST_CYCLES > LINK_TIMEOUT) ? RST_CYCLES : LINK_TIMEOUT;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam int          DW   = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_UP    = 3'd2,
    S_RETRY = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [DW-1:0]      deb_q, deb_d;
  logic [HB_BITS-1:0] hb_q, hb_d;
  logic [1:0]         sync_q, sync_d;
  logic [3:0]         retry_q, retry_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               link_ok_q, link_ok_d;
  logic               fail_q, fail_d;

  logic          lnk_s;
  logic          deb_full;
  logic [DW-1:0] deb_inc;
  logic          hold_done;
  logic          wait_done;
  logic [3:0]    retry_sat;
  logic          retry_limit;

  assign lnk_s     = sync_q[1];
  assign deb_full  = (deb_q == DW'(DEBOUNCE));
  assign deb_inc   = deb_full ? deb_q : deb_q + DW'(1);
  assign hold_done = (timer_q == TW'(RST_CYCLES - 1));
  assign wait_done = (timer_q == TW'(LINK_TIMEOUT - 1));
  assign retry_sat = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
  // retry_q already holds the incremented count while in RETRY
  assign retry_limit = (MAX_RETRY != 0) && ({28'd0, retry_q} >= MAX_RETRY);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = '0;
    deb_d   = '0;
    hb_d    = hb_q + HB_BITS'(1);
    sync_d  = {sync_q[0], bus.lnk_up};

    unique case (state_q)
      S_HOLD: begin
        timer_d = timer_q + TW'(1);
        if (bus.force_retrain)  state_d = S_RETRY;
        else if (hold_done)     state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        deb_d   = lnk_s ? deb_inc : '0;
        if (bus.force_retrain)  state_d = S_RETRY;
        else if (deb_full)      state_d = S_UP;
        else if (wait_done)     state_d = S_RETRY;
      end
      S_UP: begin
        deb_d = lnk_s ? '0 : deb_inc;
        if (bus.force_retrain || deb_full) state_d = S_RETRY;
      end
      S_RETRY: begin
        state_d = retry_limit ? S_FAIL : S_HOLD;
      end
      S_FAIL: begin
        if (bus.force_retrain) begin
          state_d = S_HOLD;
          retry_d = '0;
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      deb_d   = '0;
    end
    if (state_d == S_RETRY && state_q != S_RETRY) retry_d = retry_sat;
    if (state_d == S_UP && state_q != S_UP)       retry_d = '0;

    core_rst_n_d = (state_d == S_WAIT) || (state_d == S_UP);
    link_ok_d    = (state_d == S_UP);
    fail_d       = (state_d == S_FAIL);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_HOLD;
      timer_q      <= '0;
      deb_q        <= '0;
      hb_q         <= '0;
      sync_q       <= '0;
      retry_q      <= '0;
      core_rst_n_q <= 1'b0;
      link_ok_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      deb_q        <= deb_d;
      hb_q         <= hb_d;
      sync_q       <= sync_d;
      retry_q      <= retry_d;
      core_rst_n_q <= core_rst_n_d;
      link_ok_q    <= link_ok_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.core_rst_n = core_rst_n_q;
  assign bus.link_ok    = link_ok_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.led        = {fail_q, link_ok_q, hb_q[HB_BITS-1]};
endmodule

// File: tb/tb_pcie_7x_link_seq.sv
// Directed bench for the PCIe link sequencer: main instance with MAX_RETRY=2,
// second instance with MAX_RETRY=0 left without a link to exercise unbounded retries.
module tb_pcie_7x_link_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   errors = 0;
  logic saw_fail2 = 1'b0;
  logic hold_bad;

  pcie_7x_link_seq_if bus ();
  pcie_7x_link_seq_if bus2 ();

  pcie_7x_link_seq #(
    .RST_CYCLES(8), .LINK_TIMEOUT(64), .DEBOUNCE(4), .MAX_RETRY(2), .HB_BITS(4)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  pcie_7x_link_seq #(
    .RST_CYCLES(8), .LINK_TIMEOUT(64), .DEBOUNCE(4), .MAX_RETRY(0), .HB_BITS(4)
  ) dut_inf (
    .sys_clk(clk), .sys_rst_n(rst2_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus2.state === 3'd4) saw_fail2 = 1'b1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    rst2_n = 1'b1;
    bus.lnk_up = 1'b0;
    bus.force_retrain = 1'b0;
    bus2.lnk_up = 1'b0;
    bus2.force_retrain = 1'b0;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    chk("rst_core_rst_n", bus.core_rst_n, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_link_ok", bus.link_ok, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_retry", bus.retry_cnt, 0);
    chk("rst_led", bus.led, 0);
    #1 rst_n = 1'b1; rst2_n = 1'b1;

    // Power-up hold: 8 edges
    tick(7);                                        // edge 7
    chk("hold7_core_rst_n", bus.core_rst_n, 0);
    chk("hold7_state", bus.state, 0);
    chk("hold7_hb", bus.led[0], 0);
    tick(1);                                        // edge 8
    chk("wait8_core_rst_n", bus.core_rst_n, 1);
    chk("wait8_state", bus.state, 1);
    chk("wait8_hb", bus.led[0], 1);

    // lnk_up from cycle 20 -> UP at edge 27
    tick(12);                                       // edge 20
    bus.lnk_up = 1'b1;
    tick(6);                                        // edge 26
    chk("up26_still_wait", bus.state, 1);
    tick(1);                                        // edge 27
    chk("up27_state", bus.state, 2);
    chk("up27_link_ok", bus.link_ok, 1);
    chk("up27_retry", bus.retry_cnt, 0);
    chk("up27_led", bus.led, 3'b011);

    // 3-cycle drop is filtered
    bus.lnk_up = 1'b0;
    tick(3);                                        // edge 30
    bus.lnk_up = 1'b1;
    tick(10);                                       // edge 40
    chk("drop3_state", bus.state, 2);
    chk("drop3_link_ok", bus.link_ok, 1);

    // 4-cycle drop -> RETRY at edge 47, HOLD at 48
    bus.lnk_up = 1'b0;
    tick(4);                                        // edge 44
    bus.lnk_up = 1'b1;
    tick(2);                                        // edge 46
    chk("drop4_pre_state", bus.state, 2);
    tick(1);                                        // edge 47
    chk("drop4_state", bus.state, 3);
    chk("drop4_core_rst_n", bus.core_rst_n, 0);
    chk("drop4_retry", bus.retry_cnt, 1);
    chk("drop4_link_ok", bus.link_ok, 0);
    tick(1);                                        // edge 48
    chk("drop4_hold", bus.state, 0);
    chk("drop4_hold_retry", bus.retry_cnt, 1);

    // Re-link: WAIT at 56, UP at 61, retry_cnt cleared
    tick(13);                                       // edge 61
    chk("relink_state", bus.state, 2);
    chk("relink_retry", bus.retry_cnt, 0);

    // force_retrain in UP counts as an attempt
    bus.force_retrain = 1'b1;
    tick(1);                                        // edge 62
    bus.force_retrain = 1'b0;
    chk("force_up_state", bus.state, 3);
    chk("force_up_retry", bus.retry_cnt, 1);
    tick(1);                                        // edge 63
    chk("force_up_hold", bus.state, 0);

    // force on the debounce-complete cycle: RETRY beats UP, second attempt -> FAIL
    tick(12);                                       // edge 75
    chk("force_deb_pre", bus.state, 1);
    bus.force_retrain = 1'b1;
    tick(1);                                        // edge 76
    bus.force_retrain = 1'b0;
    chk("force_deb_state", bus.state, 3);
    chk("force_deb_link_ok", bus.link_ok, 0);
    chk("force_deb_retry", bus.retry_cnt, 2);
    tick(1);                                        // edge 77
    chk("fail77_state", bus.state, 4);
    chk("fail77_fail", bus.fail, 1);
    chk("fail77_led2", bus.led[2], 1);
    chk("fail77_core_rst_n", bus.core_rst_n, 0);

    // force in FAIL -> HOLD, UP 13 edges later with lnk_s already high
    bus.force_retrain = 1'b1;
    tick(1);                                        // edge 78
    bus.force_retrain = 1'b0;
    chk("unfail_state", bus.state, 0);
    chk("unfail_retry", bus.retry_cnt, 0);
    chk("unfail_fail", bus.fail, 0);
    tick(12);                                       // edge 90
    chk("unfail_wait", bus.state, 1);
    tick(1);                                        // edge 91
    chk("unfail_up", bus.state, 2);
    chk("unfail_link_ok", bus.link_ok, 1);

    // Link lost and never returns: RETRY 98, HOLD 99, WAIT 107, timeout 171, FAIL 172
    bus.lnk_up = 1'b0;
    tick(7);                                        // edge 98
    chk("lost_retry_state", bus.state, 3);
    chk("lost_retry_cnt", bus.retry_cnt, 1);
    tick(9);                                        // edge 107
    chk("lost_wait", bus.state, 1);
    chk("lost_wait_core", bus.core_rst_n, 1);
    tick(63);                                       // edge 170
    chk("timeout_pre", bus.state, 1);
    tick(1);                                        // edge 171
    chk("timeout_state", bus.state, 3);
    chk("timeout_retry", bus.retry_cnt, 2);
    tick(1);                                        // edge 172
    chk("nolink_fail_state", bus.state, 4);
    chk("nolink_fail", bus.fail, 1);
    chk("nolink_led2", bus.led[2], 1);
    chk("nolink_retry", bus.retry_cnt, 2);

    hold_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (bus.core_rst_n !== 1'b0 || bus.state !== 3'd4) hold_bad = 1'b1;
    end                                             // edge 1172
    chk("fail_hold_1000", hold_bad, 0);

    // Async reset mid-WAIT
    bus.force_retrain = 1'b1;
    tick(1);                                        // edge 1173 HOLD
    bus.force_retrain = 1'b0;
    tick(10);                                       // edge 1183, WAIT since 1181
    chk("midwait_state", bus.state, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_core_rst_n", bus.core_rst_n, 0);
    chk("async_state", bus.state, 0);
    chk("async_led", bus.led, 0);
    #1 rst_n = 1'b1;
    tick(7);
    chk("rehold7_state", bus.state, 0);
    chk("rehold7_core", bus.core_rst_n, 0);
    tick(1);
    chk("rehold8_state", bus.state, 1);
    chk("rehold8_core", bus.core_rst_n, 1);

    // Unbounded retries: well over 20 timeouts by now
    tick(400);
    chk("inf_retry_sat", bus2.retry_cnt, 15);
    chk("inf_never_fail", saw_fail2, 0);
    chk("inf_fail_out", bus2.fail, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
